arb21_rr: RTL
=============

Name: arb21_rr

Overview:
- Two-requester round-robin arbiter with bounded hold time, sharing one downstream resource between requesters 1 and 2.
- Produces a one-hot grant and a 1-bit encoded grant index with the same mapping as the team's 2:1 encoder: requester 1 maps to index 0, requester 2 maps to index 1.
- Sits in front of the shared datapath. The encoded index drives the datapath select directly.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles one requester may hold while the other is requesting. Legal range is 1..2^CW-1; 0 is illegal.
- CW, 4: width of the internal hold counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req1, input, 1: request from requester 1. Held high for as long as it wants the resource.
- req2, input, 1: request from requester 2, same rules as req1.
- gnt1, output, 1: grant to requester 1, registered.
- gnt2, output, 1: grant to requester 2, registered.
- gnt_valid, output, 1: high when either grant is high (gnt1 | gnt2), registered.
- gnt_idx, output, 1: encoded grant index; 0 when gnt1, 1 when gnt2, holds last value when idle. Registered.
- preempt, output, 1: one-cycle pulse on the cycle a grant is forcibly switched by the hold limit. Registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt1=0, gnt2=0, gnt_valid=0, gnt_idx=0, preempt=0.
  - state=IDLE, hold_cnt=0.
  - last=2, so requester 1 wins the first tie.
  - Reset takes effect immediately, mid-grant included, with no completion of the current grant. After release, arbitration resumes on the first rising edge at which rst_n=1.
- States: IDLE, G1, G2. gnt1=(state==G1) and gnt2=(state==G2); both come from registered state, and gnt1 and gnt2 are never both high.
- Latency: a request sampled at edge N in IDLE gives a grant visible after edge N, i.e. 1 cycle.
- IDLE:
  - req1 & ~req2 -> G1.
  - req2 & ~req1 -> G2.
  - req1 & req2 -> the requester not equal to last.
  - Neither request -> stay in IDLE.
- G1:
  - ~req1 & req2 -> G2. Back-to-back handover with no idle cycle; preempt=0.
  - ~req1 & ~req2 -> IDLE.
  - req1 & req2 & (hold_cnt==MAX_HOLD-1) -> G2 with preempt=1 for that one cycle.
  - Otherwise stay in G1.
- G2: symmetric to G1 with 1 and 2 swapped.
- last: updated to the granted requester on every entry into G1 or G2.
- hold_cnt:
  - Cleared to 0 on every state change.
  - Increments by 1 each cycle the arbiter stays in Gx while the other request is high.
  - Cleared to 0 in any Gx cycle where the other request is low, so contention must be continuous.
  - Never wraps, because the switch occurs at MAX_HOLD-1.
- Net effect under continuous contention: each grant lasts exactly MAX_HOLD cycles and grants alternate. MAX_HOLD=1 alternates every cycle.
- After preemption: the preempted requester keeps its request high and is re-granted through the normal handover or preemption path. No request is dropped.
- Requests may change on any cycle. They are sampled only at rising clk edges; no glitch filtering.
- Preempt and release on the same cycle: if the holder drops its request on the same cycle that hold_cnt hits the limit, treat it as a release, so preempt=0.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle while in G2 -> all outputs 0 immediately. Release with req1=req2=1 -> gnt1=1, gnt_idx=0 one cycle after the first edge.
- Single requester: req1=1 for 20 cycles with req2=0 -> gnt1 high for 20 cycles starting one cycle late, preempt never set, gnt_idx=0. Drop req1 -> IDLE the next cycle with gnt_valid=0.
- Handover: hold G1, drop req1 while req2=1 -> gnt2=1 and gnt_idx=1 on the next cycle with no gap cycle (gnt_valid stays 1) and preempt=0.
- Preemption, MAX_HOLD=4: req1 and req2 held high from reset -> gnt1 for 4 cycles, gnt2 for 4 cycles, repeating. Preempt pulses exactly on the first cycle of each switched grant; gnt_idx toggles 0,1,0.
- Intermittent contention, MAX_HOLD=4: in G1, req2 high for 2 cycles, low for 1, high again -> counter clears, so gnt1 persists for 4 further contended cycles before switching.
- Release on the limit cycle: req1 drops on the same cycle hold_cnt==MAX_HOLD-1 -> switch to G2 with preempt=0.

Source files
------------

// File: rtl/arb21_rr.sv
// Two-requester round-robin arbiter with a bounded hold time under contention.
// Grants, encoded index and preempt pulse all come straight from flops.
`timescale 1ns/1ps

module arb21_rr #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  output logic gnt1,
  output logic gnt2,
  output logic gnt_valid,
  output logic gnt_idx,
  output logic preempt
);

  // Encoding chosen so each grant is a single state bit with no decode logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G1   = 2'b01,
    G2   = 2'b10
  } state_e;

  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  state_e          state_q,    state_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            last2_q,    last2_d;
  logic            gnt_idx_q,  gnt_idx_d;
  logic            preempt_q,  preempt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last2_d    = last2_q;
    gnt_idx_d  = gnt_idx_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req1 && req2)  state_d = last2_q ? G1 : G2;
        else if (req1)     state_d = G1;
        else if (req2)     state_d = G2;
      end

      G1: begin
        if (!req1) begin
          state_d = req2 ? G2 : IDLE;
        end else if (req2) begin
          if (hold_cnt_q == HOLD_LIM) begin
            state_d   = G2;
            preempt_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end else begin
          hold_cnt_d = '0;
        end
      end

      G2: begin
        if (!req2) begin
          state_d = req1 ? G1 : IDLE;
        end else if (req1) begin
          if (hold_cnt_q == HOLD_LIM) begin
            state_d   = G1;
            preempt_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end else begin
          hold_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Any change of owner restarts the contention count and records the winner.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == G1) begin
        last2_d   = 1'b0;
        gnt_idx_d = 1'b0;
      end else if (state_d == G2) begin
        last2_d   = 1'b1;
        gnt_idx_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last2_q    <= 1'b1;
      gnt_idx_q  <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last2_q    <= last2_d;
      gnt_idx_q  <= gnt_idx_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt1      = state_q[0];
  assign gnt2      = state_q[1];
  assign gnt_valid = state_q[0] | state_q[1];
  assign gnt_idx   = gnt_idx_q;
  assign preempt   = preempt_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt1 && gnt2));

endmodule
